// File: rtl/siso_pkg.sv
// Shared types, constants and trellis helpers for the max-log-MAP SISO decoder
// (8-state LTE RSC code, feedback 1+D^2+D^3, feedforward 1+D+D^3).
package siso_pkg;

    localparam int K  = 7;
    localparam int LW = 4;
    localparam int EW = 12;
    localparam int MW = 16;
    localparam int NS = 8;
    localparam int WW = MW + 2;

    typedef logic signed [MW-1:0] metric_t;
    typedef logic signed [WW-1:0] wide_t;
    typedef logic signed [EW-1:0] llr_t;

    localparam metric_t NEG_INF = -16'sd16384;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAMMA,
        ST_FWD,
        ST_BWD,
        ST_DONE
    } state_t;

    // State s = 4*r1 + 2*r2 + r3, so r1 = s[2], r2 = s[1], r3 = s[0].
    function automatic logic [2:0] next_state(input logic [2:0] s, input logic u);
        logic a;
        a = u ^ s[1] ^ s[0];
        return {a, s[2], s[1]};
    endfunction

    function automatic logic parity(input logic [2:0] s, input logic u);
        logic a;
        a = u ^ s[1] ^ s[0];
        return a ^ s[2] ^ s[0];
    endfunction

    function automatic metric_t sext_ch(input logic [LW-1:0] v);
        return {{(MW-LW){v[LW-1]}}, v};
    endfunction

    function automatic metric_t sext_ext(input logic [EW-1:0] v);
        return {{(MW-EW){v[EW-1]}}, v};
    endfunction

    function automatic wide_t widen(input metric_t v);
        return {{(WW-MW){v[MW-1]}}, v};
    endfunction

    function automatic llr_t sat12(input wide_t v);
        if (v > wide_t'(2047)) begin
            return llr_t'(2047);
        end else if (v < wide_t'(-2048)) begin
            return llr_t'(-2048);
        end else begin
            return v[EW-1:0];
        end
    endfunction

endpackage

// File: rtl/siso_acs.sv
// One trellis step of add-compare-select: forward alpha update, backward beta
// update and the per-bit max-log metrics M0/M1 for the a-posteriori LLR.
module siso_acs
    import siso_pkg::*;
(
    input  metric_t alpha      [NS],
    input  metric_t beta       [NS],
    input  metric_t gamma      [4],
    output metric_t alpha_next [NS],
    output metric_t beta_prev  [NS],
    output wide_t   m0,
    output wide_t   m1
);

    logic [NS-1:0] fwd_seen;
    logic          m0_seen;
    logic          m1_seen;
    logic [2:0]    ns;
    metric_t       g;
    metric_t       fcand;
    metric_t       bcand;
    wide_t         mcand;

    // Branch metrics are indexed by {u, p}; every state has exactly two
    // incoming and two outgoing branches, so each max is a two-way compare.
    always_comb begin
        fwd_seen = '0;
        m0_seen  = 1'b0;
        m1_seen  = 1'b0;
        ns       = '0;
        g        = '0;
        fcand    = '0;
        bcand    = '0;
        mcand    = '0;
        m0       = '0;
        m1       = '0;
        for (int i = 0; i < NS; i++) begin
            alpha_next[i] = NEG_INF;
            beta_prev[i]  = NEG_INF;
        end
        for (int s = 0; s < NS; s++) begin
            for (int u = 0; u < 2; u++) begin
                ns    = next_state(3'(s), 1'(u));
                g     = gamma[{1'(u), parity(3'(s), 1'(u))}];
                fcand = alpha[s] + g;
                if (!fwd_seen[ns] || fcand > alpha_next[ns]) begin
                    alpha_next[ns] = fcand;
                    fwd_seen[ns]   = 1'b1;
                end
                bcand = g + beta[ns];
                if (u == 0 || bcand > beta_prev[s]) begin
                    beta_prev[s] = bcand;
                end
                mcand = widen(alpha[s]) + widen(g) + widen(beta[ns]);
                if (u == 0) begin
                    if (!m0_seen || mcand > m0) begin
                        m0      = mcand;
                        m0_seen = 1'b1;
                    end
                end else begin
                    if (!m1_seen || mcand > m1) begin
                        m1      = mcand;
                        m1_seen = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/siso_decoder.sv
// Max-log-MAP constituent decoder: one 7-step block per run, terminated at
// state 0 on both ends, producing saturated extrinsic LLRs.
module siso_decoder
    import siso_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              read_en_i,
    input  logic [K*LW-1:0]   sys_i,
    input  logic [K*LW-1:0]   enc_i,
    input  logic [K*EW-1:0]   ext_i,
    output logic [K*EW-1:0]   data_o,
    output logic              finish
);

    state_t          state;
    state_t          state_next;
    logic            capture;
    logic [2:0]      step;

    logic [K*LW-1:0] sys_q;
    logic [K*LW-1:0] enc_q;
    logic [K*EW-1:0] ext_q;
    logic [K*EW-1:0] res_buf;
    logic [K*EW-1:0] res_next;

    metric_t         lsum;
    metric_t         lpar;
    metric_t         gamma_calc [K][4];
    metric_t         gamma_mem  [K][4];
    metric_t         alpha_cur  [NS];
    metric_t         alpha_mem  [K][NS];
    metric_t         beta_cur   [NS];
    metric_t         acs_alpha  [NS];
    metric_t         acs_gamma  [4];
    metric_t         alpha_next [NS];
    metric_t         beta_prev  [NS];

    wide_t           m0;
    wide_t           m1;
    wide_t           lapp;
    wide_t           le_raw;
    llr_t            le;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (read_en_i) begin
                    state_next = ST_GAMMA;
                    capture    = 1'b1;
                end
            end
            ST_GAMMA: begin
                state_next = ST_FWD;
            end
            ST_FWD: begin
                if (step == 3'(K-1)) begin
                    state_next = ST_BWD;
                end
            end
            ST_BWD: begin
                if (step == 3'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                finish = 1'b1;
                if (read_en_i) begin
                    state_next = ST_GAMMA;
                    capture    = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Branch metric table index is {u, p}; x = +1 for bit 0, -1 for bit 1.
    always_comb begin
        lsum = '0;
        lpar = '0;
        for (int k = 0; k < K; k++) begin
            lsum = sext_ch(sys_q[k*LW +: LW]) + sext_ext(ext_q[k*EW +: EW]);
            lpar = sext_ch(enc_q[k*LW +: LW]);
            gamma_calc[k][0] =  lsum + lpar;
            gamma_calc[k][1] =  lsum - lpar;
            gamma_calc[k][2] = -lsum + lpar;
            gamma_calc[k][3] = -lsum - lpar;
        end
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            acs_alpha[i] = (state == ST_BWD) ? alpha_mem[step][i] : alpha_cur[i];
        end
        for (int j = 0; j < 4; j++) begin
            acs_gamma[j] = gamma_mem[step][j];
        end
    end

    siso_acs u_acs (
        .alpha      (acs_alpha),
        .beta       (beta_cur),
        .gamma      (acs_gamma),
        .alpha_next (alpha_next),
        .beta_prev  (beta_prev),
        .m0         (m0),
        .m1         (m1)
    );

    always_comb begin
        lapp     = (m0 - m1) >>> 1;
        le_raw   = lapp - widen(sext_ch(sys_q[step*LW +: LW]))
                        - widen(sext_ext(ext_q[step*EW +: EW]));
        le       = sat12(le_raw);
        res_next = res_buf;
        res_next[step*EW +: EW] = le;
    end

    // FWD walks step 0..6 and stops at 6, which is exactly where BWD starts.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            step    <= '0;
            sys_q   <= '0;
            enc_q   <= '0;
            ext_q   <= '0;
            res_buf <= '0;
            data_o  <= '0;
            for (int k = 0; k < K; k++) begin
                for (int j = 0; j < 4; j++) begin
                    gamma_mem[k][j] <= '0;
                end
                for (int i = 0; i < NS; i++) begin
                    alpha_mem[k][i] <= '0;
                end
            end
            for (int i = 0; i < NS; i++) begin
                alpha_cur[i] <= '0;
                beta_cur[i]  <= '0;
            end
        end else begin
            if (capture) begin
                sys_q <= sys_i;
                enc_q <= enc_i;
                ext_q <= ext_i;
            end
            case (state)
                ST_GAMMA: begin
                    for (int k = 0; k < K; k++) begin
                        for (int j = 0; j < 4; j++) begin
                            gamma_mem[k][j] <= gamma_calc[k][j];
                        end
                    end
                    for (int i = 0; i < NS; i++) begin
                        alpha_cur[i] <= (i == 0) ? metric_t'(0) : NEG_INF;
                        beta_cur[i]  <= (i == 0) ? metric_t'(0) : NEG_INF;
                    end
                    step <= '0;
                end
                ST_FWD: begin
                    for (int i = 0; i < NS; i++) begin
                        alpha_mem[step][i] <= alpha_cur[i];
                        alpha_cur[i]       <= alpha_next[i];
                    end
                    if (step != 3'(K-1)) begin
                        step <= step + 3'd1;
                    end
                end
                ST_BWD: begin
                    for (int i = 0; i < NS; i++) begin
                        beta_cur[i] <= beta_prev[i];
                    end
                    res_buf <= res_next;
                    if (step == 3'd0) begin
                        data_o <= res_next;
                    end else begin
                        step <= step - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siso_decoder.sv
// Self-checking bench for siso_decoder: hand-derived vectors, a behavioural
// max-log-MAP reference model, back-to-back blocks and a mid-block reset.
module tb_siso_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        read_en = 1'b0;
    logic [27:0] sys = '0;
    logic [27:0] enc = '0;
    logic [83:0] ext = '0;
    logic [83:0] data;
    logic        finish;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    siso_decoder dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .read_en_i (read_en),
        .sys_i     (sys),
        .enc_i     (enc),
        .ext_i     (ext),
        .data_o    (data),
        .finish    (finish)
    );

    typedef struct packed {
        logic [27:0] sys;
        logic [27:0] enc;
        logic [83:0] ext;
        logic [83:0] expected;
    } vec_t;

    localparam int NT = 6;
    localparam int NB = 10;

    vec_t  tbl      [NT];
    string tbl_name [NT];

    // Branch metric straight from the bipolar mapping: bit 0 -> +1, bit 1 -> -1.
    function automatic int branchMetric(input int u, input int p, input int lsys,
                                        input int lext, input int lenc);
        int xu;
        int xp;
        xu = (u == 0) ? 1 : -1;
        xp = (p == 0) ? 1 : -1;
        return xu * (lsys + lext) + xp * lenc;
    endfunction

    function automatic logic [83:0] refModel(input logic [27:0] s_in, input logic [27:0] e_in,
                                             input logic [83:0] x_in);
        int lsys [7];
        int lenc [7];
        int lext [7];
        int alpha [8][8];
        int beta  [8][8];
        int r1, r2, r3, a, p, nxt, g, cand, m0, m1, lapp, lout;
        logic [83:0] res;
        res = '0;
        for (int k = 0; k < 7; k++) begin
            lsys[k] = int'($signed(s_in[4*k +: 4]));
            lenc[k] = int'($signed(e_in[4*k +: 4]));
            lext[k] = int'($signed(x_in[12*k +: 12]));
        end
        for (int s = 0; s < 8; s++) begin
            alpha[0][s] = (s == 0) ? 0 : -16384;
            beta[7][s]  = (s == 0) ? 0 : -16384;
        end
        for (int k = 0; k < 7; k++) begin
            for (int s = 0; s < 8; s++) alpha[k+1][s] = -1000000;
            for (int s = 0; s < 8; s++) begin
                for (int u = 0; u < 2; u++) begin
                    r1 = (s / 4) % 2; r2 = (s / 2) % 2; r3 = s % 2;
                    a = u ^ r2 ^ r3; p = a ^ r1 ^ r3; nxt = 4 * a + 2 * r1 + r2;
                    g = branchMetric(u, p, lsys[k], lext[k], lenc[k]);
                    cand = alpha[k][s] + g;
                    if (cand > alpha[k+1][nxt]) alpha[k+1][nxt] = cand;
                end
            end
        end
        for (int k = 6; k >= 0; k--) begin
            for (int s = 0; s < 8; s++) beta[k][s] = -1000000;
            for (int s = 0; s < 8; s++) begin
                for (int u = 0; u < 2; u++) begin
                    r1 = (s / 4) % 2; r2 = (s / 2) % 2; r3 = s % 2;
                    a = u ^ r2 ^ r3; p = a ^ r1 ^ r3; nxt = 4 * a + 2 * r1 + r2;
                    g = branchMetric(u, p, lsys[k], lext[k], lenc[k]);
                    cand = g + beta[k+1][nxt];
                    if (cand > beta[k][s]) beta[k][s] = cand;
                end
            end
        end
        for (int k = 0; k < 7; k++) begin
            m0 = -1000000;
            m1 = -1000000;
            for (int s = 0; s < 8; s++) begin
                for (int u = 0; u < 2; u++) begin
                    r1 = (s / 4) % 2; r2 = (s / 2) % 2; r3 = s % 2;
                    a = u ^ r2 ^ r3; p = a ^ r1 ^ r3; nxt = 4 * a + 2 * r1 + r2;
                    g = branchMetric(u, p, lsys[k], lext[k], lenc[k]);
                    cand = alpha[k][s] + g + beta[k+1][nxt];
                    if (u == 0 && cand > m0) m0 = cand;
                    if (u == 1 && cand > m1) m1 = cand;
                end
            end
            lapp = (m0 - m1) >>> 1;
            lout = lapp - lsys[k] - lext[k];
            if (lout > 2047)  lout = 2047;
            if (lout < -2048) lout = -2048;
            res[12*k +: 12] = lout[11:0];
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [83:0] actual,
                               input logic [83:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitFinish(output int cycles);
        cycles = 0;
        while (finish !== 1'b1 && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic applyStimulus(input string name, input logic [27:0] s, input logic [27:0] e,
                                 input logic [83:0] x, input logic [83:0] expected);
        int cycles;
        @(negedge clk);
        sys = s; enc = e; ext = x; read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        sys = 28'($urandom());
        enc = 28'($urandom());
        ext = 84'({$urandom(), $urandom(), $urandom()});
        waitFinish(cycles);
        checkOutput({name, "_latency"}, 84'(cycles), 84'd15);
        checkOutput({name, "_data"}, data, expected);
        @(negedge clk);
        checkOutput({name, "_finish_width"}, 84'(finish), 84'd0);
        checkOutput({name, "_hold"}, data, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        int fin_count;
        logic signed [11:0] lane;
        logic [27:0] bs [NB];
        logic [27:0] be [NB];
        logic [83:0] bx [NB];
        logic [83:0] bexp [NB];
        logic [27:0] rs, re;
        logic [83:0] rx;

        tbl_name[0] = "zero";
        tbl[0] = '{sys: 28'h0, enc: 28'h0, ext: 84'h0, expected: 84'h0};
        tbl_name[1] = "allzero_cw";
        tbl[1] = '{sys: 28'h7777777, enc: 28'h7777777, ext: 84'h0, expected: 84'h0};
        tbl_name[2] = "negated_cw";
        tbl[2] = '{sys: 28'h9999999, enc: 28'h9999999, ext: 84'h0, expected: 84'h0};
        tbl_name[3] = "ext_max";
        tbl[3] = '{sys: 28'h7777777, enc: 28'h7777777, ext: {7{12'h7FF}}, expected: {7{12'h7FF}}};
        tbl_name[4] = "ext_min";
        tbl[4] = '{sys: 28'h8888888, enc: 28'h8888888, ext: {7{12'h800}}, expected: 84'h0};
        tbl_name[5] = "mixed";
        tbl[5] = '{sys: 28'h3A0F5C1, enc: 28'hE27B904,
                   ext: 84'h7FF_800_123_E00_05A_F9C_400, expected: 84'h0};
        for (int i = 1; i < NT; i++) begin
            if (i != 3) tbl[i].expected = refModel(tbl[i].sys, tbl[i].enc, tbl[i].ext);
        end

        repeat (3) @(negedge clk);
        checkOutput("reset_data", data, 84'h0);
        checkOutput("reset_finish", 84'(finish), 84'd0);
        reset_n = 1'b1;

        fin_count = 0;
        repeat (20) begin
            @(negedge clk);
            if (finish) fin_count++;
        end
        checkOutput("idle_finish_count", 84'(fin_count), 84'd0);
        checkOutput("idle_data", data, 84'h0);

        for (int i = 0; i < NT; i++) begin
            applyStimulus(tbl_name[i], tbl[i].sys, tbl[i].enc, tbl[i].ext, tbl[i].expected);
            if (i == 1) begin
                for (int k = 0; k < 7; k++) begin
                    lane = data[12*k +: 12];
                    checkOutput($sformatf("allzero_cw_positive_lane%0d", k), 84'(lane > 0), 84'd1);
                end
            end
        end

        $display("[TB] back-to-back blocks with read_en held high");
        for (int i = 0; i < NB; i++) begin
            bs[i] = 28'($urandom());
            be[i] = 28'($urandom());
            bx[i] = 84'({$urandom(), $urandom(), $urandom()});
            bexp[i] = refModel(bs[i], be[i], bx[i]);
        end
        @(negedge clk);
        sys = bs[0]; enc = be[0]; ext = bx[0]; read_en = 1'b1;
        @(negedge clk);
        sys = bs[1]; enc = be[1]; ext = bx[1];
        for (int i = 0; i < NB; i++) begin
            waitFinish(cycles);
            checkOutput($sformatf("b2b_gap%0d", i), 84'(cycles), 84'd15);
            checkOutput($sformatf("b2b_data%0d", i), data, bexp[i]);
            @(negedge clk);
            if (i + 2 < NB) begin
                sys = bs[i+2]; enc = be[i+2]; ext = bx[i+2];
            end
            if (i == NB - 2) read_en = 1'b0;
        end

        $display("[TB] reset during forward recursion");
        @(negedge clk);
        sys = 28'($urandom()); enc = 28'($urandom());
        ext = 84'({$urandom(), $urandom(), $urandom()});
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_data", data, 84'h0);
        checkOutput("abort_finish", 84'(finish), 84'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fin_count = 0;
        repeat (20) begin
            @(negedge clk);
            if (finish) fin_count++;
        end
        checkOutput("abort_no_finish", 84'(fin_count), 84'd0);
        checkOutput("abort_data_held", data, 84'h0);

        rs = 28'($urandom());
        re = 28'($urandom());
        rx = 84'({$urandom(), $urandom(), $urandom()});
        applyStimulus("after_abort", rs, re, rx, refModel(rs, re, rx));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
